// File: rtl/musicbox_env_pkg.sv
// Shared definitions for the ADSR envelope block: the envelope state type
// and the default timing/step constants used as parameter defaults.
package musicbox_env_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    localparam int DEF_TICK_DIV      = 32;   // 32 kHz / 32 = 1 kHz envelope rate
    localparam int DEF_ATTACK_STEP   = 8;
    localparam int DEF_DECAY_STEP    = 2;
    localparam int DEF_SUSTAIN_LEVEL = 160;
    localparam int DEF_RELEASE_STEP  = 4;

    // Wide enough for the largest legal TICK_DIV (1024).
    localparam int TICK_CNT_W = 10;

endpackage

// File: rtl/envelope_tick_gen.sv
// Envelope tick generator: counts 0..TICK_DIV-1 and wraps, asserting tick
// for the single cycle in which the count equals TICK_DIV-1.
// Ports:
//   CLK_32KHz - sample clock
//   reset_n   - asynchronous active-low reset
//   clear     - restart the count at 0 on the next edge
//   tick      - one-cycle envelope tick
module envelope_tick_gen
    import musicbox_env_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic CLK_32KHz,
    input  logic reset_n,
    input  logic clear,
    output logic tick
);

    localparam logic [TICK_CNT_W-1:0] LAST_COUNT = TICK_CNT_W'(TICK_DIV - 1);

    logic [TICK_CNT_W-1:0] count_r;

    assign tick = (count_r == LAST_COUNT);

    // Tick divider counter with restart on clear.
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
        end else if (clear || tick) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + TICK_CNT_W'(1);
        end
    end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR envelope generator applied to an 8-bit unsigned oscillator sample.
// Ports:
//   CLK_32KHz    - sample clock, all state updates on its rising edge
//   reset_n      - asynchronous active-low reset
//   gate         - note held
//   inputSample  - unsigned raw oscillator sample
//   outputSample - (inputSample * envLevel) >> 8, registered
//   envLevel     - current envelope level, registered
//   busy         - high whenever the envelope is not idle
module envelope_adsr
    import musicbox_env_pkg::*;
#(
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter int DECAY_STEP    = DEF_DECAY_STEP,
    parameter int SUSTAIN_LEVEL = DEF_SUSTAIN_LEVEL,
    parameter int RELEASE_STEP  = DEF_RELEASE_STEP
) (
    input  logic       CLK_32KHz,
    input  logic       reset_n,
    input  logic       gate,
    input  logic [7:0] inputSample,
    output logic [7:0] outputSample,
    output logic [7:0] envLevel,
    output logic       busy
);

    localparam logic [7:0] ATT_STEP_8 = 8'(ATTACK_STEP);
    localparam logic [7:0] DEC_STEP_8 = 8'(DECAY_STEP);
    localparam logic [7:0] SUS_LVL_8  = 8'(SUSTAIN_LEVEL);
    localparam logic [7:0] REL_STEP_8 = 8'(RELEASE_STEP);

    env_state_t         state_r;
    env_state_t         state_next_s;
    logic [7:0]         level_r;
    logic [7:0]         level_next_s;
    logic [7:0]         out_r;
    logic               busy_r;
    logic               tick_s;
    logic               clear_s;
    logic [8:0]         att_sum_s;
    logic signed [8:0]  dec_diff_s;
    logic signed [8:0]  rel_diff_s;
    logic [15:0]        product_s;

    envelope_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .CLK_32KHz (CLK_32KHz),
        .reset_n   (reset_n),
        .clear     (clear_s),
        .tick      (tick_s)
    );

    // The only multiplier in the block: raw sample scaled by the current level.
    assign product_s = 16'(inputSample) * 16'(level_r);

    // Next-state and next-level logic; a gate change always beats a same-cycle tick.
    always_comb begin
        state_next_s = state_r;
        level_next_s = level_r;
        att_sum_s    = {1'b0, level_r} + {1'b0, ATT_STEP_8};
        dec_diff_s   = $signed({1'b0, level_r}) - $signed({1'b0, DEC_STEP_8});
        rel_diff_s   = $signed({1'b0, level_r}) - $signed({1'b0, REL_STEP_8});
        case (state_r)
            ST_IDLE: begin
                level_next_s = 8'd0;
                if (gate) begin
                    state_next_s = ST_ATTACK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ATTACK: begin
                if (!gate) begin
                    state_next_s = ST_RELEASE;
                end else if (tick_s) begin
                    if (att_sum_s >= 9'd255) begin
                        level_next_s = 8'd255;
                        state_next_s = ST_DECAY;
                    end else begin
                        level_next_s = att_sum_s[7:0];
                    end
                end else begin
                    level_next_s = level_r;
                end
            end
            ST_DECAY: begin
                if (!gate) begin
                    state_next_s = ST_RELEASE;
                end else if (level_r == SUS_LVL_8) begin
                    // Already at the floor (e.g. sustain at full scale).
                    state_next_s = ST_SUSTAIN;
                end else if (tick_s) begin
                    if (dec_diff_s <= $signed({1'b0, SUS_LVL_8})) begin
                        level_next_s = SUS_LVL_8;
                        state_next_s = ST_SUSTAIN;
                    end else begin
                        level_next_s = dec_diff_s[7:0];
                    end
                end else begin
                    level_next_s = level_r;
                end
            end
            ST_SUSTAIN: begin
                if (!gate) begin
                    state_next_s = ST_RELEASE;
                end else begin
                    state_next_s = ST_SUSTAIN;
                end
            end
            ST_RELEASE: begin
                if (gate) begin
                    // Retrigger continues from the current level.
                    state_next_s = ST_ATTACK;
                end else if (tick_s) begin
                    if (rel_diff_s <= 9'sd0) begin
                        level_next_s = 8'd0;
                        state_next_s = ST_IDLE;
                    end else begin
                        level_next_s = rel_diff_s[7:0];
                    end
                end else begin
                    level_next_s = level_r;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                level_next_s = 8'd0;
            end
        endcase
        // Restart the tick phase on ATTACK entry so the first step lands TICK_DIV cycles later.
        clear_s = (state_next_s == ST_ATTACK) && (state_r != ST_ATTACK);
    end

    // State, level, busy and scaled-sample registers.
    always_ff @(posedge CLK_32KHz or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            level_r <= 8'd0;
            out_r   <= 8'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            level_r <= level_next_s;
            out_r   <= product_s[15:8];
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    assign outputSample = out_r;
    assign envLevel     = level_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_envelope_adsr.sv
// Directed bench for envelope_adsr with default parameters. Expected values
// are queued before each stimulus step and compared once the DUT has had
// the required number of edges to respond.
module tb_envelope_adsr;

    logic       clk;
    logic       reset_n;
    logic       gate;
    logic [7:0] inputSample;
    logic [7:0] outputSample;
    logic [7:0] envLevel;
    logic       busy;

    int checks_total  = 0;
    int checks_passed = 0;

    localparam int SEL_LEVEL = 0;
    localparam int SEL_OUT   = 1;
    localparam int SEL_BUSY  = 2;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } sb_t;

    sb_t sb_q[$];

    envelope_adsr dut (
        .CLK_32KHz    (clk),
        .reset_n      (reset_n),
        .gate         (gate),
        .inputSample  (inputSample),
        .outputSample (outputSample),
        .envLevel     (envLevel),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input int sel, input logic [7:0] exp);
        sb_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_all();
        sb_t e;
        logic [7:0] obs;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.sel)
                SEL_LEVEL: obs = envLevel;
                SEL_OUT:   obs = outputSample;
                SEL_BUSY:  obs = {7'd0, busy};
                default:   obs = envLevel;
            endcase
            checks_total++;
            assert (obs === e.exp) checks_passed++;
            else $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
        end
    endtask

    // Advance n rising edges, ending on a falling edge.
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n     = 1'b0;
        gate        = 1'b0;
        inputSample = 8'd0;

        // Reset state
        push("rst_level", SEL_LEVEL, 8'd0);
        push("rst_out",   SEL_OUT,   8'd0);
        push("rst_busy",  SEL_BUSY,  8'd0);
        run(3);
        check_all();
        reset_n = 1'b1;
        run(2);

        // Full attack/decay/sustain/release, edges counted from ATTACK entry
        gate        = 1'b1;
        inputSample = 8'd255;
        push("att_entry_busy",  SEL_BUSY,  8'd1);
        push("att_entry_level", SEL_LEVEL, 8'd0);
        run(1);                                       // E0
        check_all();
        push("att_pre_tick1", SEL_LEVEL, 8'd0);
        run(31);                                      // E31
        check_all();
        push("att_tick1", SEL_LEVEL, 8'd8);
        run(1);                                       // E32
        check_all();
        push("att_tick31", SEL_LEVEL, 8'd248);
        run(991);                                     // E1023
        check_all();
        push("att_peak",     SEL_LEVEL, 8'd255);
        push("out_lvl248",   SEL_OUT,   8'd247);      // 255*248>>8
        run(1);                                       // E1024
        check_all();
        push("out_lvl255", SEL_OUT, 8'd254);
        run(1);                                       // E1025
        check_all();
        push("dec_tick47", SEL_LEVEL, 8'd161);
        run(1534);                                    // E2559
        check_all();
        push("dec_floor", SEL_LEVEL, 8'd160);
        run(1);                                       // E2560
        check_all();
        push("out_lvl160", SEL_OUT, 8'd159);
        run(1);                                       // E2561
        check_all();
        inputSample = 8'd100;
        push("out_in100", SEL_OUT, 8'd62);            // 100*160>>8
        run(1);                                       // E2562
        check_all();
        inputSample = 8'd0;
        push("out_in0", SEL_OUT, 8'd0);
        run(1);                                       // E2563
        check_all();
        inputSample = 8'd255;
        push("sus_hold", SEL_LEVEL, 8'd160);
        run(316);                                     // E2879
        check_all();
        gate = 1'b0;                                  // RELEASE entry on a tick-aligned edge
        push("rel_entry_level", SEL_LEVEL, 8'd160);
        push("rel_entry_busy",  SEL_BUSY,  8'd1);
        run(1);                                       // E2880
        check_all();
        push("rel_tick1", SEL_LEVEL, 8'd156);
        run(32);
        check_all();
        push("rel_tick39", SEL_LEVEL, 8'd4);
        run(1247);
        check_all();
        push("rel_zero", SEL_LEVEL, 8'd0);
        run(1);                                       // 1280 cycles after RELEASE entry
        check_all();
        push("idle_busy", SEL_BUSY, 8'd0);
        push("idle_out",  SEL_OUT,  8'd0);
        run(1);
        check_all();

        // Gate drop exactly on an ATTACK tick at level 96
        gate = 1'b1;
        push("b_entry_level", SEL_LEVEL, 8'd0);
        run(1);                                       // E0
        check_all();
        push("b_att_88", SEL_LEVEL, 8'd88);
        run(383);                                     // E383
        check_all();
        push("b_att_96", SEL_LEVEL, 8'd96);
        run(1);                                       // E384
        check_all();
        run(31);                                      // E415: tick cycle
        gate = 1'b0;
        push("b_drop_level", SEL_LEVEL, 8'd96);
        push("b_drop_busy",  SEL_BUSY,  8'd1);
        run(1);                                       // E416
        check_all();
        push("b_rel_pre", SEL_LEVEL, 8'd96);
        run(31);                                      // E447
        check_all();
        push("b_rel_92", SEL_LEVEL, 8'd92);
        run(1);                                       // E448
        check_all();
        push("b_rel_40", SEL_LEVEL, 8'd40);
        run(416);                                     // E864
        check_all();

        // Retrigger from RELEASE at level 40
        gate = 1'b1;
        push("rt_entry_level", SEL_LEVEL, 8'd40);
        push("rt_entry_busy",  SEL_BUSY,  8'd1);
        run(1);                                       // E865
        check_all();
        push("rt_pre_tick", SEL_LEVEL, 8'd40);
        run(31);
        check_all();
        push("rt_tick1", SEL_LEVEL, 8'd48);
        run(1);                                       // E897
        check_all();
        push("rt_peak", SEL_LEVEL, 8'd255);
        run(832);                                     // E1729
        check_all();
        // 201 is the nearest DECAY level to 200 reachable with the default steps
        push("rt_dec_201", SEL_LEVEL, 8'd201);
        run(864);                                     // E2593
        check_all();

        // Asynchronous reset in the middle of a cycle during DECAY
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        push("async_level", SEL_LEVEL, 8'd0);
        push("async_out",   SEL_OUT,   8'd0);
        push("async_busy",  SEL_BUSY,  8'd0);
        #1;
        check_all();
        @(negedge clk);
        run(2);
        reset_n = 1'b1;                               // gate still high
        push("post_rst_level", SEL_LEVEL, 8'd0);
        push("post_rst_busy",  SEL_BUSY,  8'd1);
        run(1);
        check_all();
        push("post_rst_tick1", SEL_LEVEL, 8'd8);
        run(32);
        check_all();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
